branch_redirect_ctrl: RTL and testbench
=======================================

# branch_redirect_ctrl

Pipeline-side controller for the branch target buffer predictor. It carries the ID-stage prediction into EX and checks it against the resolved jump outcome. On a misprediction it redirects the PC and squashes the wrong-path instructions. It also sequences a full BTB invalidate sweep on request and keeps branch/mispredict statistics. Sits between the predictor, the PC mux and the IF/ID and ID/EX pipeline registers.

## Interface

Parameters:
- BTB_DEPTH, 64, number of predictor entries swept by an invalidate; power of two.
- CNT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  pipeline clock; everything samples on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_is_jump  in  1  instruction in ID is a jump/branch.
- id_pc  in  32  PC of the instruction in ID.
- pred_taken  in  1  predictor hit with counter state 2'b10/2'b11 for id_pc.
- pred_target  in  32  predicted target from the BTB.
- ex_is_jump  in  1  instruction in EX is a jump/branch.
- ex_pc  in  32  PC of the instruction in EX.
- ex_do_jump  in  1  resolved outcome: taken.
- ex_target  in  32  resolved jump target.
- stall_in  in  1  hazard unit freezes IF/ID this cycle.
- clr_req  in  1  one-cycle request to invalidate the whole BTB.
- pc_sel  out  2  0=SEQ (pc+4), 1=PREDICT, 2=REDIRECT.
- redirect_pc  out  32  PC to load when pc_sel=PREDICT or REDIRECT.
- flush_if_id  out  1  squash IF/ID contents.
- flush_id_ex  out  1  load a bubble into ID/EX.
- stall_out  out  1  freeze IF and ID (stall_in OR clear sweep).
- btb_clr_en  out  1  BTB write-enable to zero entry btb_clr_idx.
- btb_clr_idx  out  log2(BTB_DEPTH)  entry being cleared.
- busy  out  1  clear sweep in progress.
- clr_done  out  1  one-cycle pulse after the last entry is cleared.
- cnt_branch  out  CNT_W  resolved jumps seen in EX.
- cnt_mispred  out  CNT_W  mispredictions seen in EX.

## Operation

- Prediction tag register pq = {valid, taken, target, pc}, loaded from ID when the ID/EX register advances.
  - Loaded when stall_out=0 and there is no flush; valid = id_is_jump.
  - Loaded with valid=0 when stall_out=1 or flush_id_ex=1.
- Resolution when ex_is_jump=1. Predicted taken = pq.valid && pq.pc==ex_pc && pq.taken.
- Mispredict when:
  - predicted taken != ex_do_jump, or
  - both taken and pq.target != ex_target.
- On mispredict:
  - pc_sel=REDIRECT.
  - redirect_pc = ex_do_jump ? ex_target : ex_pc+4 (32-bit wrap).
  - flush_if_id=1 and flush_id_ex=1.
- Otherwise, if id_is_jump && pred_taken && stall_out=0: pc_sel=PREDICT and redirect_pc=pred_target. Otherwise pc_sel=SEQ and redirect_pc=0.
- Priority: EX mispredict > clear sweep stall > ID predict > SEQ.
- A flush overrides stall_in for the squashed registers.
- FSM states:
  - RUN: normal operation.
  - CLEAR: walks idx 0..BTB_DEPTH-1, one entry per cycle, with btb_clr_en=1, busy=1 and stall_out=1. ID predictions are ignored. EX still resolves normally. After the last index, go to DONE.
  - DONE: clr_done=1 for one cycle, then return to RUN.
- clr_req is taken only in RUN. In CLEAR or DONE it is ignored.
- If clr_req arrives in the same cycle as a mispredict, the redirect happens in that cycle and CLEAR starts on the next edge.
- Counters:
  - cnt_branch increments on every ex_is_jump.
  - cnt_mispred increments on every mispredict.
  - Both saturate at all-ones, never wrap.

## Timing

- pc_sel, redirect_pc, flush_if_id, flush_id_ex and stall_out are combinational on the current inputs and state. A redirect takes effect on the same cycle's edge, giving a 2-cycle mispredict penalty.
- Everything else is registered:
  - pq, FSM state, btb_clr_idx.
  - Counters update on the edge after the event.
- Clear sweep: CLEAR is entered on the edge that samples clr_req. btb_clr_en is high for exactly BTB_DEPTH cycles with idx 0..BTB_DEPTH-1. clr_done is high in the next cycle. stall_out drops in the cycle after clr_done.
- Reset values: state RUN; pq.valid=0; btb_clr_idx=0; btb_clr_en=0; busy=0; clr_done=0; counters 0.
- rst during CLEAR aborts the sweep immediately. No clr_done pulse is produced.

## Structure

- Shared package:
  - pc_sel encodings (PC_SEQ, PC_PREDICT, PC_REDIRECT).
  - FSM state encodings (RUN, CLEAR, DONE).
  - BTB_DEPTH default and index-width constant, shared with the predictor.
- One sub-module: sat_counter (CNT_W wide, inc input, saturating), instantiated twice.

## Test plan

- ID jump at 0x40 with pred_taken=1, pred_target=0x100; next cycle EX jump at 0x40 with do_jump=1, target 0x100 -> pc_sel=PREDICT in the ID cycle, no flush; cnt_branch=1, cnt_mispred=0.
- Predicted taken 0x40->0x100, EX resolves not-taken -> pc_sel=REDIRECT, redirect_pc=0x44, both flushes high for 1 cycle; cnt_mispred=1.
- Not predicted (pred_taken=0), EX at 0x80 taken to 0x200 -> redirect_pc=0x200. Same case with a stale BTB target 0x1F0 and pred_taken=1 -> redirect_pc=0x200.
- clr_req pulse -> btb_clr_en high for 64 cycles with idx 0..63; stall_out high throughout; clr_done one cycle later. A second clr_req mid-sweep is ignored.
- clr_req coincident with a mispredict -> REDIRECT in that cycle, sweep starts next cycle. rst at idx 20 -> all outputs return to reset values, no clr_done.
- Preload cnt_mispred to all-ones minus 1, drive 3 mispredicts -> counter holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/brc_pkg.sv
// Shared types for the BTB redirect controller.
// Used by the predictor-side pipeline control.
package brc_pkg;

  localparam int unsigned BTB_DEPTH_DEF = 64;
  localparam int unsigned BTB_IDX_W     = $clog2(BTB_DEPTH_DEF);

  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_PREDICT  = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        taken;
    logic [31:0] target;
    logic [31:0] pc;
  } pq_t;

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating event counter.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // next count, stuck at the top value
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// BTB prediction check, PC redirect and squash,
// invalidate sweep sequencing and statistics.
module branch_redirect_ctrl
  import brc_pkg::*;
#(
  parameter int unsigned BTB_DEPTH = BTB_DEPTH_DEF,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         id_is_jump,
  input  logic [31:0]                  id_pc,
  input  logic                         pred_taken,
  input  logic [31:0]                  pred_target,
  input  logic                         ex_is_jump,
  input  logic [31:0]                  ex_pc,
  input  logic                         ex_do_jump,
  input  logic [31:0]                  ex_target,
  input  logic                         stall_in,
  input  logic                         clr_req,
  output logic [1:0]                   pc_sel,
  output logic [31:0]                  redirect_pc,
  output logic                         flush_if_id,
  output logic                         flush_id_ex,
  output logic                         stall_out,
  output logic                         btb_clr_en,
  output logic [$clog2(BTB_DEPTH)-1:0] btb_clr_idx,
  output logic                         busy,
  output logic                         clr_done,
  output logic [CNT_W-1:0]             cnt_branch,
  output logic [CNT_W-1:0]             cnt_mispred
);

  localparam int unsigned IDX_W = $clog2(BTB_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BTB_DEPTH - 1);

  pq_t              pq_q, pq_d;
  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             clr_en_q;
  logic             busy_q;
  logic             done_q;

  logic             sweep;
  logic             pred_hit;
  logic             mispred;
  logic             id_predict;

  // EX check against the carried prediction and PC mux select
  always_comb begin
    sweep      = (state_q != ST_RUN);
    pred_hit   = pq_q.valid && pq_q.taken &&
                 (pq_q.pc == ex_pc);
    mispred    = ex_is_jump &&
                 ((pred_hit != ex_do_jump) ||
                  (pred_hit && (pq_q.target != ex_target)));
    stall_out  = stall_in | sweep;
    id_predict = id_is_jump && pred_taken && !stall_out;
    flush_if_id = mispred;
    flush_id_ex = mispred;
    pc_sel      = PC_SEQ;
    redirect_pc = '0;
    priority case (1'b1)
      mispred: begin
        pc_sel      = PC_REDIRECT;
        redirect_pc = ex_do_jump ? ex_target
                                 : ex_pc + 32'd4;
      end
      id_predict: begin
        pc_sel      = PC_PREDICT;
        redirect_pc = pred_target;
      end
      default: ;
    endcase
  end

  // ID/EX copy of the prediction, bubbled on stall or squash
  always_comb begin
    pq_d = '0;
    if (!stall_out && !mispred) begin
      pq_d.valid  = id_is_jump;
      pq_d.taken  = pred_taken;
      pq_d.target = pred_target;
      pq_d.pc     = id_pc;
    end
  end

  // prediction tag register
  always_ff @(posedge clk) begin
    if (rst) begin
      pq_q <= '0;
    end else begin
      pq_q <= pq_d;
    end
  end

  // invalidate sweep FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_RUN;
      idx_q    <= '0;
      clr_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          done_q <= 1'b0;
          if (clr_req) begin
            state_q  <= ST_CLEAR;
            idx_q    <= '0;
            clr_en_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_CLEAR: begin
          if (idx_q == LAST_IDX) begin
            state_q  <= ST_DONE;
            idx_q    <= '0;
            clr_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_RUN;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_RUN;
        end
      endcase
    end
  end

  assign btb_clr_en  = clr_en_q;
  assign btb_clr_idx = idx_q;
  assign busy        = busy_q;
  assign clr_done    = done_q;

  sat_counter #(.W(CNT_W)) u_cnt_branch (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (ex_is_jump),
    .count_o (cnt_branch)
  );

  sat_counter #(.W(CNT_W)) u_cnt_mispred (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (mispred),
    .count_o (cnt_mispred)
  );

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: directed table,
// corner sequences and a random run vs a model.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_is_jump;
  logic [31:0] id_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_is_jump;
  logic [31:0] ex_pc;
  logic        ex_do_jump;
  logic [31:0] ex_target;
  logic        stall_in;
  logic        clr_req;

  logic [1:0]  pc_sel;
  logic [31:0] redirect_pc;
  logic        flush_if_id, flush_id_ex, stall_out;
  logic        btb_clr_en, busy, clr_done;
  logic [5:0]  btb_clr_idx;
  logic [31:0] cnt_branch, cnt_mispred;

  logic [1:0]  s_pc_sel;
  logic [31:0] s_redirect_pc;
  logic        s_fl1, s_fl2, s_stall;
  logic        s_en, s_busy, s_done;
  logic [5:0]  s_idx;
  logic [3:0]  s_cb, s_cm;

  always #5 clk = ~clk;

  branch_redirect_ctrl u_dut (
    .clk(clk), .rst(rst),
    .id_is_jump(id_is_jump), .id_pc(id_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_do_jump(ex_do_jump), .ex_target(ex_target),
    .stall_in(stall_in), .clr_req(clr_req),
    .pc_sel(pc_sel), .redirect_pc(redirect_pc),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .stall_out(stall_out), .btb_clr_en(btb_clr_en),
    .btb_clr_idx(btb_clr_idx), .busy(busy),
    .clr_done(clr_done), .cnt_branch(cnt_branch),
    .cnt_mispred(cnt_mispred)
  );

  branch_redirect_ctrl #(.BTB_DEPTH(64), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst),
    .id_is_jump(id_is_jump), .id_pc(id_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_is_jump(ex_is_jump), .ex_pc(ex_pc),
    .ex_do_jump(ex_do_jump), .ex_target(ex_target),
    .stall_in(stall_in), .clr_req(clr_req),
    .pc_sel(s_pc_sel), .redirect_pc(s_redirect_pc),
    .flush_if_id(s_fl1), .flush_id_ex(s_fl2),
    .stall_out(s_stall), .btb_clr_en(s_en),
    .btb_clr_idx(s_idx), .busy(s_busy),
    .clr_done(s_done), .cnt_branch(s_cb),
    .cnt_mispred(s_cm)
  );

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  // reference model state
  bit          m_valid, m_taken;
  logic [31:0] m_tgt, m_pc;
  int          m_pos;   // -1 idle, 0..63 clearing, 64 done
  longint      m_nb, m_nm;
  bit          e_mis, e_stall;

  function automatic longint sat(input longint v,
                                 input int w);
    longint top = (longint'(1) << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_taken = 0;
    m_tgt = 0;   m_pc = 0;
    m_pos = -1;  m_nb = 0; m_nm = 0;
  endtask

  // wait to mid-cycle and compare every output with the model
  task automatic check_now(input bit en);
    bit          ptk, swp, clr;
    logic [1:0]  x_sel;
    logic [31:0] x_rpc;
    logic [5:0]  x_idx;
    #4;
    ptk = m_valid && m_taken && (m_pc == ex_pc);
    e_mis = ex_is_jump &&
            ((ptk != ex_do_jump) ||
             (ptk && m_tgt != ex_target));
    swp = (m_pos >= 0);
    clr = (m_pos >= 0) && (m_pos < 64);
    e_stall = stall_in || swp;
    x_sel = 2'd0; x_rpc = 0;
    if (e_mis) begin
      x_sel = 2'd2;
      x_rpc = ex_do_jump ? ex_target : ex_pc + 4;
    end else if (id_is_jump && pred_taken && !e_stall) begin
      x_sel = 2'd1;
      x_rpc = pred_target;
    end
    x_idx = clr ? 6'(m_pos) : 6'd0;
    if (!en) return;
    chk("pc_sel", pc_sel, x_sel);
    chk("redirect_pc", redirect_pc, x_rpc);
    chk("flush_if_id", flush_if_id, e_mis);
    chk("flush_id_ex", flush_id_ex, e_mis);
    chk("stall_out", stall_out, e_stall);
    chk("btb_clr_en", btb_clr_en, clr);
    chk("btb_clr_idx", btb_clr_idx, x_idx);
    chk("busy", busy, clr);
    chk("clr_done", clr_done, m_pos == 64);
    chk("cnt_branch", cnt_branch, sat(m_nb, 32));
    chk("cnt_mispred", cnt_mispred, sat(m_nm, 32));
    chk("small_outs",
        {s_pc_sel, s_redirect_pc, s_fl1, s_fl2, s_stall,
         s_en, s_idx, s_busy, s_done},
        {x_sel, x_rpc, e_mis, e_mis, e_stall,
         clr, x_idx, clr, m_pos == 64});
    chk("small_cnt_branch", s_cb, sat(m_nb, 4));
    chk("small_cnt_mispred", s_cm, sat(m_nm, 4));
  endtask

  // clock edge: advance the model with the sampled inputs
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_stall || e_mis) begin
        m_valid = 0; m_taken = 0;
      end else begin
        m_valid = id_is_jump; m_taken = pred_taken;
        m_tgt = pred_target;  m_pc = id_pc;
      end
      if (ex_is_jump) m_nb++;
      if (e_mis) m_nm++;
      if (m_pos == 64)     m_pos = -1;
      else if (m_pos >= 0) m_pos++;
      else if (clr_req)    m_pos = 0;
    end
    #1;
  endtask

  task automatic idle();
    id_is_jump = 0; id_pc = 0; pred_taken = 0;
    pred_target = 0; ex_is_jump = 0; ex_pc = 0;
    ex_do_jump = 0; ex_target = 0; stall_in = 0;
    clr_req = 0;
  endtask

  typedef struct {
    logic        idj;
    logic [31:0] idpc;
    logic        pt;
    logic [31:0] ptgt;
    logic        exj;
    logic [31:0] expc;
    logic        dj;
    logic [31:0] extgt;
    logic        stl;
    logic [1:0]  x_sel;
    logic [31:0] x_rpc;
    logic        x_fl;
    logic        x_stall;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 0,
                2'd1, 32'h100, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 1, 32'h40, 1, 32'h100, 0,
                2'd0, 0, 0, 0};
    tbl[2]  = '{1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 0,
                2'd1, 32'h100, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 32'h40, 0, 32'h100, 0,
                2'd2, 32'h44, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,
                2'd0, 0, 0, 0};
    tbl[5]  = '{1, 32'h80, 0, 0, 0, 0, 0, 0, 0,
                2'd0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 1, 32'h80, 1, 32'h200, 0,
                2'd2, 32'h200, 1, 0};
    tbl[7]  = '{1, 32'h80, 1, 32'h1F0, 0, 0, 0, 0, 0,
                2'd1, 32'h1F0, 0, 0};
    tbl[8]  = '{0, 0, 0, 0, 1, 32'h80, 1, 32'h200, 0,
                2'd2, 32'h200, 1, 0};
    tbl[9]  = '{1, 32'h40, 1, 32'h100, 0, 0, 0, 0, 1,
                2'd0, 0, 0, 1};
    tbl[10] = '{0, 0, 0, 0, 1, 32'h40, 1, 32'h100, 0,
                2'd2, 32'h100, 1, 0};
    tbl[11] = '{0, 0, 0, 0, 1, 32'h40, 0, 0, 0,
                2'd0, 0, 0, 0};
    tbl[12] = '{1, 32'hFFFFFFFC, 1, 32'h10, 0, 0, 0, 0, 0,
                2'd1, 32'h10, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 1, 32'hFFFFFFFC, 0, 0, 0,
                2'd2, 32'h0, 1, 0};

    idle();
    rst = 1;
    model_reset();
    check_now(0); tick();
    check_now(0); tick();
    check_now(1); tick();
    rst = 0;

    // reset state
    check_now(1);
    chk("rst_cnt_branch", cnt_branch, 0);
    chk("rst_btb_clr_en", btb_clr_en, 0);
    chk("rst_clr_done", clr_done, 0);
    tick();

    // directed table
    for (int i = 0; i < 14; i++) begin
      id_is_jump = tbl[i].idj;  id_pc = tbl[i].idpc;
      pred_taken = tbl[i].pt;   pred_target = tbl[i].ptgt;
      ex_is_jump = tbl[i].exj;  ex_pc = tbl[i].expc;
      ex_do_jump = tbl[i].dj;   ex_target = tbl[i].extgt;
      stall_in   = tbl[i].stl;
      check_now(1);
      chk($sformatf("tbl%0d_sel", i), pc_sel, tbl[i].x_sel);
      chk($sformatf("tbl%0d_rpc", i), redirect_pc,
          tbl[i].x_rpc);
      chk($sformatf("tbl%0d_flush", i),
          {flush_if_id, flush_id_ex}, {2{tbl[i].x_fl}});
      chk($sformatf("tbl%0d_stall", i), stall_out,
          tbl[i].x_stall);
      tick();
    end
    idle();
    check_now(1);
    chk("tbl_cnt_branch", cnt_branch, 7);
    chk("tbl_cnt_mispred", cnt_mispred, 5);
    tick();

    // full sweep with an ignored second request
    clr_req = 1;
    check_now(1);
    chk("sweep_req_en", btb_clr_en, 0);
    tick();
    clr_req = 0;
    id_is_jump = 1; id_pc = 32'h40;
    pred_taken = 1; pred_target = 32'h300;
    for (int i = 0; i < 64; i++) begin
      clr_req = (i == 10);
      check_now(1);
      chk($sformatf("sweep_en%0d", i), btb_clr_en, 1);
      chk($sformatf("sweep_idx%0d", i), btb_clr_idx, i);
      chk($sformatf("sweep_stall%0d", i), stall_out, 1);
      chk($sformatf("sweep_sel%0d", i), pc_sel, 0);
      tick();
    end
    clr_req = 0;
    check_now(1);
    chk("sweep_done", clr_done, 1);
    chk("sweep_done_en", btb_clr_en, 0);
    chk("sweep_done_stall", stall_out, 1);
    tick();
    check_now(1);
    chk("sweep_after_stall", stall_out, 0);
    chk("sweep_after_done", clr_done, 0);
    chk("sweep_after_sel", pc_sel, 1);
    tick();
    idle();
    check_now(1); tick();

    // clear request together with a mispredict, then abort
    id_is_jump = 1; id_pc = 32'h40;
    pred_taken = 1; pred_target = 32'h100;
    check_now(1); tick();
    idle();
    ex_is_jump = 1; ex_pc = 32'h40; ex_do_jump = 0;
    clr_req = 1;
    check_now(1);
    chk("coinc_sel", pc_sel, 2);
    chk("coinc_rpc", redirect_pc, 32'h44);
    chk("coinc_en", btb_clr_en, 0);
    tick();
    idle();
    for (int i = 0; i <= 20; i++) begin
      check_now(1);
      chk($sformatf("coinc_idx%0d", i), btb_clr_idx, i);
      if (i == 20) rst = 1;
      tick();
    end
    rst = 0;
    check_now(1);
    chk("abort_en", btb_clr_en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_stall", stall_out, 0);
    chk("abort_cnt", cnt_branch, 0);
    tick();
    for (int i = 0; i < 70; i++) begin
      check_now(1);
      chk("abort_no_done", clr_done, 0);
      tick();
    end

    // saturation of the 4-bit counters
    ex_is_jump = 1; ex_pc = 32'h500;
    ex_do_jump = 1; ex_target = 32'h600;
    for (int i = 0; i < 14; i++) begin
      check_now(1); tick();
    end
    check_now(1);
    chk("sat_m14", s_cm, 14);
    for (int i = 0; i < 3; i++) begin
      tick(); check_now(1);
    end
    chk("sat_m_hold", s_cm, 15);
    chk("sat_b_hold", s_cb, 15);
    chk("sat_wide", cnt_mispred, 17);
    tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pool[4];
      pool[0] = 32'h40; pool[1] = 32'h80;
      pool[2] = 32'hC0; pool[3] = 32'hFFFFFFFC;
      rst         = ($urandom_range(0, 499) == 0);
      clr_req     = ($urandom_range(0, 99) == 0);
      stall_in    = ($urandom_range(0, 4) == 0);
      id_is_jump  = $urandom_range(0, 1);
      id_pc       = pool[$urandom_range(0, 3)];
      pred_taken  = $urandom_range(0, 1);
      pred_target = $urandom_range(0, 1) ? 32'h100 : 32'h200;
      ex_is_jump  = $urandom_range(0, 1);
      ex_pc       = pool[$urandom_range(0, 3)];
      ex_do_jump  = $urandom_range(0, 1);
      ex_target   = $urandom_range(0, 1) ? 32'h100 : 32'h200;
      check_now(1);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
